// File: rtl/hwpe_stream_tcdm_responder.sv
// -----------------------------------------------------------------------------
// hwpe_stream_tcdm_responder
//
// TCDM slave endpoint backed by an internal word-addressed memory. Each
// request is granted after a programmable number of wait states. Read data
// appears exactly one cycle after the read handshake. Two saturating counters
// track stall cycles and granted transactions for performance checks.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clear_i             synchronous soft clear (memory contents kept)
//   wait_i              wait cycles inserted before each grant
//   tcdm_req_i/gnt_o    request / grant handshake
//   tcdm_add_i          byte address (word index from ADDR_LSB upwards)
//   tcdm_wen_i          1 = read, 0 = write
//   tcdm_be_i           byte enables for writes
//   tcdm_data_i         write data
//   tcdm_r_data_o       read data (holds value when r_valid is low)
//   tcdm_r_valid_o      read response valid
//   nb_stall_o          cycles with req=1 and gnt=0 (saturating)
//   nb_txn_o            granted transactions (saturating)
// -----------------------------------------------------------------------------
module hwpe_stream_tcdm_responder #(
  parameter int NB_WORDS   = 256,
  parameter int ADDR_LSB   = 2,
  parameter int WAIT_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [WAIT_WIDTH-1:0] wait_i,
  input  logic                  tcdm_req_i,
  output logic                  tcdm_gnt_o,
  input  logic [31:0]           tcdm_add_i,
  input  logic                  tcdm_wen_i,
  input  logic [3:0]            tcdm_be_i,
  input  logic [31:0]           tcdm_data_i,
  output logic [31:0]           tcdm_r_data_o,
  output logic                  tcdm_r_valid_o,
  output logic [CNT_WIDTH-1:0]  nb_stall_o,
  output logic [CNT_WIDTH-1:0]  nb_txn_o
);

  localparam int IDX_W = $clog2(NB_WORDS);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                state_q;
  logic [WAIT_WIDTH-1:0] cnt_q;
  logic [IDX_W-1:0]      idx;
  logic                  handshake;
  logic                  stall;
  logic [31:0]           mem [NB_WORDS];

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{tcdm_add_i[31:ADDR_LSB+IDX_W], tcdm_add_i[ADDR_LSB-1:0]};

  assign idx       = tcdm_add_i[ADDR_LSB +: IDX_W];
  assign handshake = tcdm_req_i & tcdm_gnt_o;
  assign stall     = tcdm_req_i & ~tcdm_gnt_o;

  // Grant is combinational on req so that wait_i=0 gives a zero-wait
  // handshake. It is masked during reset and clear so nothing can be granted
  // while the state is being wiped. The counter holds the number of cycles
  // the current request has already waited; a counter above wait_i (after
  // wait_i was lowered) grants immediately.
  always_comb begin
    tcdm_gnt_o = 1'b0;
    if (tcdm_req_i && !clear_i && !rst_i) begin
      case (state_q)
        ST_IDLE: tcdm_gnt_o = (wait_i == '0);
        ST_WAIT: tcdm_gnt_o = (cnt_q >= wait_i);
        default: tcdm_gnt_o = 1'b0;
      endcase
    end
  end

  // Grant FSM. Leaving IDLE with an ungranted request means one wait cycle
  // has already been spent, hence the counter starts at 1 in WAIT. A
  // withdrawn request or a handshake sends the FSM back to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stall) begin
            state_q <= ST_WAIT;
            cnt_q   <= WAIT_WIDTH'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          if (!tcdm_req_i || tcdm_gnt_o) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + WAIT_WIDTH'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Backing store. Only byte lanes with their enable set are written.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (handshake && !tcdm_wen_i) begin
      for (int k = 0; k < 4; k++) begin
        if (tcdm_be_i[k]) begin
          mem[idx][8*k +: 8] <= tcdm_data_i[8*k +: 8];
        end
      end
    end
  end

  // Read response path. r_data only moves on a read handshake, so it keeps
  // the last returned word while r_valid is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcdm_r_valid_o <= 1'b0;
      tcdm_r_data_o  <= '0;
    end else if (clear_i) begin
      tcdm_r_valid_o <= 1'b0;
      tcdm_r_data_o  <= '0;
    end else if (handshake && tcdm_wen_i) begin
      tcdm_r_valid_o <= 1'b1;
      tcdm_r_data_o  <= mem[idx];
    end else begin
      tcdm_r_valid_o <= 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      nb_stall_o <= '0;
      nb_txn_o   <= '0;
    end else if (clear_i) begin
      nb_stall_o <= '0;
      nb_txn_o   <= '0;
    end else begin
      if (stall && (nb_stall_o != '1)) begin
        nb_stall_o <= nb_stall_o + CNT_WIDTH'(1);
      end
      if (handshake && (nb_txn_o != '1)) begin
        nb_txn_o <= nb_txn_o + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/hwpe_stream_tcdm_responder.md
Name: hwpe_stream_tcdm_responder

Overview:
- TCDM slave endpoint: accepts requests on the TCDM slave side and serves them from an internal word-addressed memory.
- Grants after a programmable number of wait states; returns read data exactly one cycle after the read handshake.
- Intended as the memory-side counterpart to HWPE streamer/TCDM master logic, in testbenches and small standalone accelerator scratchpads.
- Also provides stall and transaction counters for performance checks.

Parameters:
- NB_WORDS, 256, memory depth in 32-bit words; must be a power of 2 and at least 2.
- ADDR_LSB, 2, lowest byte-address bit used for the word index.
- WAIT_WIDTH, 4, width of the wait-state configuration input.
- CNT_WIDTH, 16, width of the statistic counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous soft clear (active high).
- wait_i  in  WAIT_WIDTH  number of wait cycles inserted before each grant.
- tcdm_req_i  in  1  request.
- tcdm_gnt_o  out  1  grant.
- tcdm_add_i  in  32  byte address.
- tcdm_wen_i  in  1  1 = read, 0 = write.
- tcdm_be_i  in  4  byte enables (writes only).
- tcdm_data_i  in  32  write data.
- tcdm_r_data_o  out  32  read data.
- tcdm_r_valid_o  out  1  read response valid.
- nb_stall_o  out  CNT_WIDTH  count of cycles with req=1 and gnt=0.
- nb_txn_o  out  CNT_WIDTH  count of granted transactions.

Behaviour:
- Reset (rst_i=1, asynchronous): wait counter=0; r_valid_o=0; r_data_o=0; both counters=0; all memory words=0.
- clear_i=1: same effect as reset on the wait counter, r_valid, r_data and counters, applied synchronously. Memory contents are kept. gnt_o is forced to 0 while clear_i=1.
- Word index = tcdm_add_i[ADDR_LSB +: log2(NB_WORDS)]. Upper address bits are ignored, so addresses alias modulo NB_WORDS*4.
- Grant FSM:
  - IDLE: wait counter=0.
  - In IDLE with req=1: if wait_i=0, gnt_o=req combinationally (zero-wait handshake). Otherwise move to WAIT.
  - WAIT: counter increments each cycle while req=1. gnt_o=1 in the cycle where counter==wait_i and req=1.
  - On the handshake (req&gnt), counter returns to 0 and the FSM returns to IDLE.
  - wait_i is re-sampled every cycle. If the counter already exceeds wait_i, grant immediately.
- Request withdrawn before grant (protocol violation): counter returns to 0 and the FSM returns to IDLE. No memory access occurs.
- Back-to-back requests: each request pays wait_i wait cycles. With wait_i=0, one transaction per cycle is sustained.
- Write (handshake with wen=0): at the clock edge, byte k of the word is updated iff be[k]=1. r_valid_o=0 in the next cycle.
- Read (handshake with wen=1): r_valid_o=1 and r_data_o=mem[index] in exactly the next cycle. be is ignored.
- r_data_o holds its last value when r_valid_o=0.
- Read-after-write to the same word in consecutive handshakes: the read returns the post-write value.
- Counters:
  - nb_stall_o increments on each cycle with req=1 and gnt=0.
  - nb_txn_o increments on each handshake.
  - Both saturate at all-ones; no wrap.
- Reset asserted mid-transaction: the pending grant and any pending r_valid are dropped immediately, with no glitched gnt after release.

Test Plan:
- wait_i=0: write 0xDEADBEEF to addr 0x10 (be=0xF), then read 0x10 in the next cycle -> gnt is high in both request cycles; r_valid=1 one cycle after the read handshake with r_data=0xDEADBEEF; nb_txn=2, nb_stall=0.
- Partial write: word 0x04 holds 0x11223344; write 0xAABBCCDD with be=0x5 -> a subsequent read returns 0x11BB33DD.
- wait_i=3, single read held asserted -> gnt rises on the 4th request cycle; r_valid arrives on the 5th; nb_stall=3.
- Aliasing with NB_WORDS=256: write 0x5 to addr 0x400, read addr 0x000 -> r_data=0x5.
- wait_i=2, req dropped after 1 cycle then reasserted -> no access on the drop; the counter restarts and gnt comes after 2 further wait cycles.
- rst_i pulsed one cycle after a read handshake -> r_valid stays 0 and counters read 0; memory reads 0 afterwards. Same scenario using clear_i instead -> memory contents are preserved.
